// File: rtl/chain_pkg.sv
// chain_pkg: shared state encoding and sizing for the shift-chain driver.
// The default chain length is defined here unless it was already supplied
// on the build command line; it also serves as the word width.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

package chain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } chain_state_t;

  localparam int CHAIN_CNT_W = $clog2(`DATA_LEN);

endpackage

// File: rtl/chain_bit_counter.sv
// chain_bit_counter: counts shift cycles; term_o flags the last shift (DATA_LEN-1).
// Latency: term_o is combinational from the registered count.
// Backpressure: none; clear has priority over increment, and the count never wraps within a transfer.
// Ports: clk_i/reset_i (sync, active-high), clr_i, inc_i, term_o.
module chain_bit_counter
  import chain_pkg::*;
#(
  parameter int DATA_LEN = `DATA_LEN,
  parameter int CNT_W    = CHAIN_CNT_W
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DATA_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/chain_driver.sv
// chain_driver: serialises a parallel word LSB-first into a register shift chain and captures the returning bits.
// Latency: handshake edge -> first shift 1 cycle, -> chain_update DATA_LEN+1 cycles, rd_valid one cycle after that.
// Backpressure: in_ready is high only in IDLE; in_valid in any other state is ignored.
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready word input;
//        chain_data_out/chain_enable/chain_update/chain_data_in chain side;
//        rd_data/rd_valid readback; busy; rd_mismatch loopback check.
// Optional macro CHAIN_VERIFY_EN: compare each readback with the word written one transfer earlier.
module chain_driver
  import chain_pkg::*;
#(
  parameter int DATA_LEN = `DATA_LEN,
  parameter int CNT_W    = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                chain_data_out,
  output logic                chain_enable,
  output logic                chain_update,
  input  logic                chain_data_in,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                busy,
  output logic                rd_mismatch
);

  chain_state_t        state_q, state_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [DATA_LEN-1:0] rb_q, rb_d;
  logic [DATA_LEN-1:0] rd_data_q, rd_data_d;
  logic                cnt_clr, cnt_inc, cnt_term;

  chain_bit_counter #(
    .DATA_LEN(DATA_LEN),
    .CNT_W   (CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_o (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rb_d      = rb_q;
    rd_data_d = rd_data_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Outgoing bit leaves from bit 0; the returning bit enters at the top so
        // the first bit back ends up in bit 0 after DATA_LEN shifts.
        shift_d = {1'b0, shift_q[DATA_LEN-1:1]};
        rb_d    = {chain_data_in, rb_q[DATA_LEN-1:1]};
        cnt_inc = 1'b1;
        if (cnt_term) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        rd_data_d = rb_q;
        state_d   = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      rb_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rb_q      <= rb_d;
      rd_data_q <= rd_data_d;
    end
  end

  // All strobes decode directly from the state register, so enable and update
  // are mutually exclusive by construction.
  assign in_ready       = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign chain_enable   = (state_q == SHIFT);
  assign chain_data_out = (state_q == SHIFT) & shift_q[0];
  assign chain_update   = (state_q == UPDATE);
  assign rd_valid       = (state_q == DONE);
  assign rd_data        = rd_data_q;

`ifdef CHAIN_VERIFY_EN
  logic [DATA_LEN-1:0] word_q;
  logic [DATA_LEN-1:0] last_q;
  logic                have_prev_q;
  logic                mism_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q      <= '0;
      last_q      <= '0;
      have_prev_q <= 1'b0;
      mism_q      <= 1'b0;
    end else begin
      if ((state_q == IDLE) && in_valid) begin
        word_q <= in_data;
      end
      if (state_q == UPDATE) begin
        // The chain returns what was written one transfer ago; with no
        // earlier write since reset there is nothing to compare against.
        mism_q      <= have_prev_q && (rb_q != last_q);
        last_q      <= word_q;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign rd_mismatch = mism_q;
`else
  assign rd_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_chain_driver.sv
// tb_chain_driver: directed bench for chain_driver with an 8-cell behavioural chain model.
module tb_chain_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       chain_data_out;
  logic       chain_enable;
  logic       chain_update;
  logic       chain_data_in;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       rd_mismatch;

  int checks = 0;
  int errors = 0;

  // Behavioural chain: head is cell 7, tail (returning bit) is cell 0.
  logic [7:0] chain_m = 8'h00;
  int         shift_cnt = 0;
  logic       loop_en = 1'b0;
  logic       flip_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (chain_enable) begin
      chain_m   <= {chain_data_out, chain_m[7:1]};
      shift_cnt <= shift_cnt + 1;
    end else begin
      shift_cnt <= 0;
    end
  end

  assign chain_data_in = loop_en ? (chain_m[0] ^ (flip_en && (shift_cnt == 2))) : 1'b0;

  chain_driver #(.DATA_LEN(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .chain_data_out(chain_data_out),
    .chain_enable  (chain_enable),
    .chain_update  (chain_update),
    .chain_data_in (chain_data_in),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
    .rd_mismatch   (rd_mismatch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer starting from IDLE; returns readback, mismatch flag and
  // whether rd_valid arrived within the cycle budget.
  task automatic xfer(input logic [7:0] w, output logic [7:0] rd, output logic mm, output logic ok);
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !rd_valid; c++) @(negedge clk);
    ok = rd_valid;
    rd = rd_data;
    mm = rd_mismatch;
    @(negedge clk);
  endtask

  logic [7:0] exp_w;
  logic [7:0] rd;
  logic       mm;
  logic       ok;
  int         bad;
  int         acc_cyc[$];
  logic [7:0] acc_w[$];
  logic [7:0] rdq[$];

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(chain_enable), 32'd0);
    check("rst_update", 32'(chain_update), 32'd0);
    check("rst_data_out", 32'(chain_data_out), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_mismatch", 32'(rd_mismatch), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word 0xA5 with chain tail tied low
    exp_w    = 8'hA5;
    in_data  = exp_w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("a5_in_ready_drop", 32'(in_ready), 32'd0);
    check("a5_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a5_enable_%0d", i), 32'(chain_enable), 32'd1);
      check($sformatf("a5_bit_%0d", i), 32'(chain_data_out), 32'(exp_w[i]));
      check($sformatf("a5_no_update_%0d", i), 32'(chain_update), 32'd0);
      @(negedge clk);
    end
    check("a5_update", 32'(chain_update), 32'd1);
    check("a5_enable_off", 32'(chain_enable), 32'd0);
    check("a5_no_rd_valid_yet", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("a5_rd_valid", 32'(rd_valid), 32'd1);
    check("a5_rd_data", 32'(rd_data), 32'h00);
    check("a5_update_once", 32'(chain_update), 32'd0);
    check("a5_mismatch", 32'(rd_mismatch), 32'd0);
    @(negedge clk);
    check("a5_idle_ready", 32'(in_ready), 32'd1);
    check("a5_rd_valid_once", 32'(rd_valid), 32'd0);
    check("a5_rd_data_hold", 32'(rd_data), 32'h00);

    // Loopback: chain currently holds 0xA5
    loop_en = 1'b1;
    xfer(8'h3C, rd, mm, ok);
    check("lb1_done", 32'(ok), 32'd1);
    check("lb1_rd_data", 32'(rd), 32'hA5);
    check("lb1_mismatch", 32'(mm), 32'd0);
    xfer(8'hC3, rd, mm, ok);
    check("lb2_done", 32'(ok), 32'd1);
    check("lb2_rd_data", 32'(rd), 32'h3C);
    check("lb2_mismatch", 32'(mm), 32'd0);

    // Corrupt the third returning bit: 0xC3 comes back as 0xC7
    flip_en = 1'b1;
    xfer(8'h5A, rd, mm, ok);
    flip_en = 1'b0;
    check("flip_done", 32'(ok), 32'd1);
    check("flip_rd_data", 32'(rd), 32'hC7);
`ifdef CHAIN_VERIFY_EN
    check("flip_mismatch", 32'(mm), 32'd1);
`else
    check("flip_mismatch", 32'(mm), 32'd0);
`endif

    // Reset during the 4th shift cycle
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_shift", 32'(chain_enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_enable", 32'(chain_enable), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_rd_data", 32'(rd_data), 32'h00);
    check("abort_mismatch", 32'(rd_mismatch), 32'd0);
    reset = 1'b0;
    bad   = 0;
    repeat (15) begin
      @(negedge clk);
      if (chain_update || rd_valid || chain_enable) bad++;
    end
    check("abort_quiet", 32'(bad), 32'd0);
    check("abort_rd_data_hold", 32'(rd_data), 32'h00);

    // in_valid held high with in_data changing every cycle
    bad = 0;
    for (int k = 0; k < 34; k++) begin
      in_data  = 8'(16 + k);
      in_valid = 1'b1;
      if (in_ready) begin
        acc_cyc.push_back(k);
        acc_w.push_back(in_data);
      end
      if (rd_valid) rdq.push_back(rd_data);
      if (chain_enable && chain_update) bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !rd_valid; c++) begin
      if (chain_enable && chain_update) bad++;
      @(negedge clk);
    end
    check("stream_last_done", 32'(rd_valid), 32'd1);
    check("stream_last_rd", 32'(rd_data), 32'h26);
    @(negedge clk);
    check("stream_overlap", 32'(bad), 32'd0);
    check("stream_n_accept", 32'(acc_cyc.size()), 32'd4);
    check("stream_n_rd", 32'(rdq.size()), 32'd3);
    if (acc_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("stream_acc_cyc_%0d", i), 32'(acc_cyc[i]), 32'(11 * i));
        check($sformatf("stream_acc_w_%0d", i), 32'(acc_w[i]), 32'(16 + 11 * i));
      end
    end
    if (rdq.size() == 3) begin
      check("stream_rd1", 32'(rdq[1]), 32'h10);
      check("stream_rd2", 32'(rdq[2]), 32'h1B);
    end

    // in_valid pulsed during SHIFT must be ignored
    in_data  = 8'h81;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_data  = 8'h77;
    in_valid = 1'b1;
    check("ign_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 20 && !rd_valid; c++) begin
      if (in_ready) bad++;
      @(negedge clk);
    end
    check("ign_done", 32'(rd_valid), 32'd1);
    check("ign_rd_data", 32'(rd_data), 32'h31);
    check("ign_ready_low", 32'(bad), 32'd0);
    @(negedge clk);
    check("ign_idle", 32'(in_ready), 32'd1);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (chain_enable || busy) bad++;
    end
    check("ign_no_second", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
